// File: rtl/enable_cadence_rx.sv
// Receive side of the fractional clock-enable scheme: captures strobed samples into a
// first-word-fall-through FIFO and watches the strobe cadence for bad windows.
module enable_cadence_rx #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned INPUT_CYCLES  = 3,
  parameter int unsigned OUTPUT_PULSES = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_en,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          cadence_err,
  output logic [ERR_CNT_WIDTH-1:0]      err_count,
  input  logic                          clear_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned WinW = (INPUT_CYCLES > 1) ? $clog2(INPUT_CYCLES) : 1;
  localparam int unsigned PcW  = $clog2(INPUT_CYCLES + 1);

  logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]          level_q, level_d;
  logic [DATA_WIDTH-1:0]    last_q;
  logic                     full, push, pop, drop;

  logic [WinW-1:0]          win_q;
  logic [PcW-1:0]           pulse_q, pulse_total;
  logic                     mask_q, win_end, bad_win;
  logic                     overflow_q, cad_err_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  assign out_valid = (level_q != '0);
  assign full      = (level_q == LvlW'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  // A full FIFO still takes a sample when the head leaves in the same cycle.
  assign push      = in_en & (~full | pop);
  assign drop      = in_en & full & ~pop;

  assign out_data    = out_valid ? mem_q[rd_ptr_q] : last_q;
  assign fifo_level  = level_q;
  assign overflow    = overflow_q;
  assign cadence_err = cad_err_q;
  assign err_count   = err_cnt_q;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
    end
  end

  // Count includes the strobe of the window's final cycle.
  assign win_end     = (win_q == WinW'(INPUT_CYCLES - 1));
  assign pulse_total = pulse_q + PcW'(in_en);
  assign bad_win     = win_end & ~mask_q & (pulse_total != PcW'(OUTPUT_PULSES));

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clear_err) begin
      err_cnt_d = bad_win ? ERR_CNT_WIDTH'(1) : '0;
    end else if (bad_win && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q      <= '0;
      pulse_q    <= '0;
      mask_q     <= 1'b1;
      overflow_q <= 1'b0;
      cad_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      win_q      <= win_end ? '0 : win_q + 1'b1;
      pulse_q    <= win_end ? '0 : pulse_total;
      if (win_end) mask_q <= 1'b0;
      overflow_q <= (overflow_q & ~clear_err) | drop;
      cad_err_q  <= (cad_err_q & ~clear_err) | bad_win;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_enable_cadence_rx.sv
// Self-checking bench for enable_cadence_rx: queue scoreboard for the FIFO path plus
// a cycle model of the cadence monitor and sticky flags.
module tb_enable_cadence_rx;

  localparam int DW = 16;
  localparam int D  = 4;
  localparam int LW = 3;
  localparam int IC = 3;
  localparam int OP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_en;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          cadence_err;
  logic [7:0]    err_count;
  logic          clear_err;

  enable_cadence_rx dut (
    .clk        (clk),
    .rst        (rst),
    .in_en      (in_en),
    .in_data    (in_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .cadence_err(cadence_err),
    .err_count  (err_count),
    .clear_err  (clear_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int pops        = 0;
  logic [DW-1:0] seq = 16'h0;

  logic [DW-1:0] sb[$];
  bit m_ovf, m_cad, m_mask;
  int m_err, m_win, m_pc;

  task automatic model_reset();
    sb.delete();
    m_ovf = 0; m_cad = 0; m_err = 0; m_win = 0; m_pc = 0; m_mask = 1;
  endtask

  // One clock: compare the head before the edge, advance the model, compare state after.
  task automatic drive(input bit en, input logic [DW-1:0] d, input bit rdy, input bit clr);
    bit pop, bad, ovf_ev, ending;
    int total;
    logic exp_v;
    in_en = en; in_data = d; out_ready = rdy; clear_err = clr;
    exp_v = (sb.size() > 0);
    vectors++;
    if (out_valid !== exp_v) begin
      miscompares++;
      $display("FAIL valid: got %b want %b", out_valid, exp_v);
    end
    pop = rdy && (sb.size() > 0);
    if (pop) begin
      vectors++;
      if (out_data !== sb[0]) begin
        miscompares++;
        $display("FAIL pop_data: got %h want %h", out_data, sb[0]);
      end
      void'(sb.pop_front());
      pops++;
    end
    ovf_ev = 0;
    if (en) begin
      if (sb.size() < D) sb.push_back(d);
      else ovf_ev = 1;
    end
    ending = (m_win == IC - 1);
    total  = m_pc + int'(en);
    bad    = ending && !m_mask && (total != OP);
    if (clr) begin
      m_ovf = ovf_ev; m_cad = bad; m_err = bad ? 1 : 0;
    end else begin
      m_ovf = m_ovf | ovf_ev; m_cad = m_cad | bad;
      if (bad && m_err < 255) m_err++;
    end
    m_pc = ending ? 0 : total;
    if (ending) m_mask = 0;
    m_win = ending ? 0 : m_win + 1;
    @(posedge clk); #1;
    vectors++;
    if (fifo_level !== LW'(sb.size()) || overflow !== m_ovf || cadence_err !== m_cad ||
        err_count !== 8'(m_err)) begin
      miscompares++;
      $display("FAIL state: got lvl=%0d ovf=%b cad=%b err=%0d want lvl=%0d ovf=%b cad=%b err=%0d",
               fifo_level, overflow, cadence_err, err_count, sb.size(), m_ovf, m_cad, m_err);
    end
  endtask

  task automatic window(input bit b0, input bit b1, input bit b2, input bit rdy,
                        input bit clr_last);
    drive(b0, seq, rdy, 1'b0); seq++;
    drive(b1, seq, rdy, 1'b0); seq++;
    drive(b2, seq, rdy, clr_last); seq++;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_en = 0; in_data = '0; out_ready = 0; clear_err = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_en = 0; in_data = '0; out_ready = 0; clear_err = 0;
    model_reset();
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || fifo_level !== '0 || overflow !== 1'b0 ||
        cadence_err !== 1'b0 || err_count !== '0) begin
      miscompares++;
      $display("FAIL reset: got v=%b d=%h lvl=%0d ovf=%b cad=%b err=%0d want all zero",
               out_valid, out_data, fifo_level, overflow, cadence_err, err_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    for (int w = 0; w < 10; w++) begin
      for (int c = 0; c < 3; c++) begin
        logic [DW-1:0] d;
        d = seq;
        drive(c != 2, d, 1'b1, 1'b0);
        seq++;
        vectors++;
        if (fifo_level > 1 || (c != 2 && (out_valid !== 1'b1 || out_data !== d))) begin
          miscompares++;
          $display("FAIL stream_latency: got v=%b d=%h lvl=%0d want v=1 d=%h lvl<=1",
                   out_valid, out_data, fifo_level, d);
        end
      end
    end
    vectors++;
    if (cadence_err !== 1'b0 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL stream_cadence: got cad=%b err=%0d want 0 0", cadence_err, err_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, 16'h100 + 16'(i), 1'b0, 1'b0);
    vectors++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1 || out_data !== 16'h100) begin
      miscompares++;
      $display("FAIL overflow: got lvl=%0d ovf=%b d=%h want 4 1 0100",
               fifo_level, overflow, out_data);
    end
    pops = 0;
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (pops != 4 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_drain: got pops=%0d v=%b want 4 0", pops, out_valid);
    end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 16'h200 + 16'(i), 1'b0, 1'b0);
    drive(1'b1, 16'h2AA, 1'b1, 1'b0);
    vectors++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0 || out_data !== 16'h201) begin
      miscompares++;
      $display("FAIL full_pushpop: got lvl=%0d ovf=%b d=%h want 4 0 0201",
               fifo_level, overflow, out_data);
    end
    pops = 0;
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (pops != 4) begin
      miscompares++;
      $display("FAIL full_drain: got pops=%0d want 4", pops);
    end
  endtask

  task automatic test_cadence();
    do_reset();
    for (int w = 0; w < 5; w++) window(1, 1, 0, 1'b1, 1'b0);
    window(1, 0, 0, 1'b1, 1'b0);
    window(1, 1, 0, 1'b1, 1'b0);
    window(1, 1, 0, 1'b1, 1'b0);
    window(1, 1, 1, 1'b1, 1'b0);
    window(1, 1, 0, 1'b1, 1'b0);
    vectors++;
    if (err_count !== 8'd2 || cadence_err !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL cadence: got err=%0d cad=%b ovf=%b want 2 1 0",
               err_count, cadence_err, overflow);
    end
  endtask

  task automatic test_clear_collision();
    window(1, 0, 0, 1'b1, 1'b1);
    vectors++;
    if (err_count !== 8'd1 || cadence_err !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_collision: got err=%0d cad=%b want 1 1", err_count, cadence_err);
    end
  endtask

  task automatic test_clear();
    drive(1'b1, seq, 1'b1, 1'b1); seq++;
    vectors++;
    if (err_count !== 8'd0 || cadence_err !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL clear: got err=%0d cad=%b ovf=%b want 0 0 0",
               err_count, cadence_err, overflow);
    end
    drive(1'b1, seq, 1'b1, 1'b0); seq++;
    drive(1'b0, seq, 1'b1, 1'b0); seq++;
  endtask

  task automatic test_midstream_reset();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h300 + 16'(i), 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || fifo_level !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b lvl=%0d want 0 0", out_valid, fifo_level);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    window(0, 0, 0, 1'b1, 1'b0);
    vectors++;
    if (cadence_err !== 1'b0 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL startup_mask: got cad=%b err=%0d want 0 0", cadence_err, err_count);
    end
    window(1, 1, 0, 1'b1, 1'b0);
    window(0, 1, 0, 1'b1, 1'b0);
    vectors++;
    if (cadence_err !== 1'b1 || err_count !== 8'd1) begin
      miscompares++;
      $display("FAIL post_mask: got cad=%b err=%0d want 1 1", cadence_err, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_full_pushpop();
    test_cadence();
    test_clear_collision();
    test_clear();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
